// File: rtl/sw_debounce_pkg.sv
// Shared constants for the sw_debounce8 switch/button conditioning block.
// The SW_DEBOUNCE_BYPASS_EN macro is consumed by debounce_bit, not here.
package sw_debounce_pkg;

  localparam int TICK_DIV_DEF     = 50000;
  localparam int STABLE_TICKS_DEF = 4;
  localparam int SW_WIDTH         = 8;

  // Counter must hold 0..STABLE_TICKS; never narrower than one bit.
  function automatic int cnt_width(input int stable_ticks);
    return (stable_ticks < 1) ? 1 : $clog2(stable_ticks + 1);
  endfunction

endpackage

// File: rtl/sw_debounce8_debounce_bit.sv
// One debounce channel: debounced level plus a 1-cycle update strobe.
// With SW_DEBOUNCE_BYPASS_EN defined the channel just registers its input.
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic upd
);

  logic db_q, db_d;
  logic upd_q, upd_d;

`ifdef SW_DEBOUNCE_BYPASS_EN
  logic unused_tick;
  assign unused_tick = tick;

  always_comb begin
    db_d  = din;
    upd_d = (db_d != db_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_q  <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      db_q  <= db_d;
      upd_q <= upd_d;
    end
  end
`else
  localparam int CW = cnt_width(STABLE_TICKS);

  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle of agreement restarts the count, tick or not.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (din == db_q) begin
      cnt_d = '0;
    end else if (tick && (cnt_q == CW'(STABLE_TICKS - 1))) begin
      db_d  = din;
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end
    upd_d = (db_d != db_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
      upd_q <= 1'b0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
      upd_q <= upd_d;
    end
  end
`endif

  assign dout = db_q;
  assign upd  = upd_q;

endmodule

// File: rtl/sw_debounce8.sv
// Synchronises and debounces 8 slide switches plus an enable push-button.
// Define SW_DEBOUNCE_BYPASS_EN to drop the prescaler and debounce counters.
module sw_debounce8
  import sw_debounce_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SW_WIDTH-1:0] sw_raw,
  input  logic                btn_raw,
  output logic [SW_WIDTH-1:0] sw_db,
  output logic                en_out,
  output logic                changed
);

  localparam int NCH = SW_WIDTH + 1;

  logic [NCH-1:0] sync1_q, sync1_d;
  logic [NCH-1:0] sync2_q, sync2_d;
  logic [NCH-1:0] db;
  logic [NCH-1:0] upd;
  logic           tick;
  logic           btn_dly_q, btn_dly_d;
  logic           en_q, en_d;
  logic           changed_q, changed_d;

  // Button rides in the top channel so all nine share one chain.
  always_comb begin
    sync1_d = {btn_raw, sw_raw};
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef SW_DEBOUNCE_BYPASS_EN
  assign tick = 1'b0;
`else
  localparam int PW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    tick  = (pre_q == PW'(TICK_DIV - 1));
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .din  (sync2_q[i]),
      .dout (db[i]),
      .upd  (upd[i])
    );
  end

  logic unused_btn_upd;
  assign unused_btn_upd = upd[SW_WIDTH];

  // Only the press edge toggles; the release and a long hold do nothing.
  always_comb begin
    btn_dly_d = db[SW_WIDTH];
    en_d      = en_q ^ (db[SW_WIDTH] & ~btn_dly_q);
    changed_d = |upd[SW_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_dly_q <= 1'b0;
      en_q      <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      btn_dly_q <= btn_dly_d;
      en_q      <= en_d;
      changed_q <= changed_d;
    end
  end

  assign sw_db   = db[SW_WIDTH-1:0];
  assign en_out  = en_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_sw_debounce8.sv
// Self-checking bench for sw_debounce8 with TICK_DIV=4, STABLE_TICKS=3.
// Build with SW_DEBOUNCE_BYPASS_EN to exercise the bypassed variant.
module tb_sw_debounce8;

`ifdef SW_DEBOUNCE_BYPASS_EN
  localparam int LAT_MIN = 3;
  localparam int LAT_MAX = 3;
`else
  localparam int LAT_MIN = 11;
  localparam int LAT_MAX = 14;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw_raw;
  logic       btn_raw;
  logic [7:0] sw_db;
  logic       en_out;
  logic       changed;

  sw_debounce8 #(.TICK_DIV(4), .STABLE_TICKS(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_raw (sw_raw),
    .btn_raw(btn_raw),
    .sw_db  (sw_db),
    .en_out (en_out),
    .changed(changed)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] val;
    int         t0;
  } exp_t;

  typedef struct {
    logic [7:0] sw;
    logic [7:0] exp_sw;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];

  int   expected_updates = 0;
  int   changed_pulses   = 0;
  int   en_toggles       = 0;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Every queued update must have appeared by now.
  task automatic drain_check(input string name);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s: %0d expected update(s) never appeared, want 0",
               name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] sw);
    if (sw !== sw_raw) begin
      exp_t e;
      e.val = sw;
      e.t0  = cyc;
      sb_q.push_back(e);
      expected_updates++;
    end
    sw_raw = sw;
  endtask

  // Output monitor: pops the scoreboard whenever sw_db moves.
  logic [7:0] prev_db     = 8'h00;
  logic       prev_en     = 1'b0;
  logic       changed_due = 1'b0;
  logic       rst_at_edge = 1'b1;

  always @(negedge clk) begin
    if (rst_at_edge) begin
      check_output("reset_sw_db", sw_db, 32'h0);
      check_output("reset_changed", changed, 32'h0);
      check_output("reset_en_out", en_out, 32'h0);
      prev_db     = 8'h00;
      prev_en     = 1'b0;
      changed_due = 1'b0;
    end else begin
      check_output("changed_strobe", changed, changed_due);
      if (changed === 1'b1) changed_pulses++;
      changed_due = 1'b0;
      if (sw_db !== prev_db) begin
        changed_due = 1'b1;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_update: got %02h want %02h", sw_db, prev_db);
        end else begin
          exp_t e;
          int   lat;
          e   = sb_q.pop_front();
          lat = cyc - e.t0;
          check_output("update_value", sw_db, e.val);
          total++;
          if (lat < LAT_MIN || lat > LAT_MAX) begin
            bad++;
            $display("[TB] FAIL update_latency: got %0d want %0d..%0d",
                     lat, LAT_MIN, LAT_MAX);
          end
        end
      end
      if (en_out !== prev_en) en_toggles++;
      prev_db = sw_db;
      prev_en = en_out;
    end
    rst_at_edge = !rst_n;
  end

  initial begin
    vecs[0] = '{sw: 8'h00, exp_sw: 8'h00};
    vecs[1] = '{sw: 8'h81, exp_sw: 8'h81};
    vecs[2] = '{sw: 8'h81, exp_sw: 8'h81};
    vecs[3] = '{sw: 8'h7E, exp_sw: 8'h7E};
    vecs[4] = '{sw: 8'h80, exp_sw: 8'h80};
    vecs[5] = '{sw: 8'h00, exp_sw: 8'h00};

    rst_n   = 1'b0;
    sw_raw  = 8'hFF;
    btn_raw = 1'b1;
    step(3);

    // Release reset with switches already high: one update to FF.
    sw_raw  = 8'h00;
    btn_raw = 1'b0;
    rst_n   = 1'b1;
    apply_stimulus(8'hFF);
    step(20);
    check_output("reset_release_sw_db", sw_db, 32'hFF);
    drain_check("reset_release_update");

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].sw);
      step(20);
      check_output("table_sw_db", sw_db, vecs[i].exp_sw);
      drain_check("table_update");
    end

`ifndef SW_DEBOUNCE_BYPASS_EN
    // Five high, one low: never three ticks of unbroken mismatch.
    for (int i = 0; i < 60; i++) begin
      sw_raw[3] = ((i % 6) != 5);
      step(1);
    end
    sw_raw[3] = 1'b0;
    step(20);
    check_output("glitch_sw_db", sw_db, 32'h0);
`endif

    btn_raw = 1'b1;
    step(20);
    check_output("press1_en_out", en_out, 32'h1);
    btn_raw = 1'b0;
    step(20);
    check_output("release1_en_out", en_out, 32'h1);
`ifndef SW_DEBOUNCE_BYPASS_EN
    btn_raw = 1'b1;
    step(1);
    btn_raw = 1'b0;
    step(1);
`endif
    btn_raw = 1'b1;
    step(20);
    check_output("press2_en_out", en_out, 32'h0);
    btn_raw = 1'b0;
    step(20);
    check_output("release2_en_out", en_out, 32'h0);
    check_output("en_toggle_count", en_toggles, 32'd2);

`ifndef SW_DEBOUNCE_BYPASS_EN
    // Partial count on bit 7 must be lost across the reset pulse.
    sw_raw = 8'h80;
    step(8);
    rst_n = 1'b0;
    step(1);
    rst_n  = 1'b1;
    sw_raw = 8'h00;
    step(20);
    check_output("reset_mid_sw_db", sw_db, 32'h0);
    drain_check("reset_mid_update");
`endif

    check_output("changed_pulse_count", changed_pulses, expected_updates);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
